// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: accepts a parallel operand pair plus bit length over
// valid/ready and streams it LSB-first as (vld, a, b, last) for the serial adder.
// Optional build macro SERIAL_OPERAND_FEEDER_WORD_CNT_EN adds an 8-bit count of
// completed words (word_cnt).
//
// state | meaning
// IDLE  | no word in flight, in_ready=1, outputs quiet
// SHIFT | presenting sh_a[0]/sh_b[0]; cnt = bits remaining after this one
module serial_operand_feeder #(
    parameter int W  = 8,
    parameter int LW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [LW-1:0] in_len,
    input  logic          pause,
    output logic          vld,
    output logic          a,
    output logic          b,
    output logic          last
`ifdef SERIAL_OPERAND_FEEDER_WORD_CNT_EN
    ,
    output logic [7:0]    word_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t        state, state_next;
    logic [W-1:0]  sh_a, sh_b;
    logic [LW-1:0] cnt;
    logic          load, shift;
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);

    // State register; reset drops any in-flight word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state decode, handshake and serial outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        vld        = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                // rst gating keeps in_ready low while reset is asserted
                in_ready = rst;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                vld = !pause;
                if (!pause) begin
                    if (cnt_zero) begin
                        // final bit: take the next word with no bubble
                        in_ready = 1'b1;
                        if (in_valid) load = 1'b1;
                        else          state_next = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        a    = sh_a[0] & vld;
        b    = sh_b[0] & vld;
        last = vld & cnt_zero;
    end

    // Operand shift registers and down-counter of remaining bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_a <= '0;
            sh_b <= '0;
            cnt  <= '0;
        end else if (load) begin
            sh_a <= in_a;
            sh_b <= in_b;
            cnt  <= in_len;
        end else if (shift) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            cnt  <= cnt - LW'(1);
        end
    end

`ifdef SERIAL_OPERAND_FEEDER_WORD_CNT_EN
    // Completed-word counter, wraps naturally at 256.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             word_cnt <= '0;
        else if (vld && last) word_cnt <= word_cnt + 8'd1;
    end
`endif

endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Transmit side for the team's serial adder with valid.
- Accepts two parallel operands plus a bit length over a valid/ready handshake.
- Streams the operands LSB-first as serial (vld, a, b, last) in exactly the format the serial adder consumes, and allows caller-inserted gaps.
- Sits between a parallel producer (CPU-side register or FIFO) and the serial datapath.

Parameters:
- W, 8: maximum operand width in bits; legal for W >= 2.
- LW, $clog2(W): width of in_len.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has an operand pair.
- in_ready  output  1  feeder accepts the pair on this posedge.
- in_a  input  W  operand A, bit 0 is sent first.
- in_b  input  W  operand B, bit 0 is sent first.
- in_len  input  LW  number of bits to send, minus 1 (0 means 1 bit, W-1 means W bits).
- pause  input  1  caller-requested gap; suppresses vld and holds shifting.
- vld  output  1  serial bit valid.
- a  output  1  serial bit of A.
- b  output  1  serial bit of B.
- last  output  1  current bit is the final bit of the word.

Behaviour:
- Reset:
  - Reset is rst, asynchronous, active-low; clock is clk.
  - While rst=0: state IDLE, shift registers 0, counter 0.
  - While rst=0: vld=0, a=0, b=0, last=0, in_ready=0.
  - In-flight word is discarded; no partial completion after release.
- State machine:
  - IDLE: in_ready=1. On posedge with in_valid=1:
    - Load sh_a=in_a, sh_b=in_b, cnt=in_len.
    - Go to SHIFT.
  - SHIFT, combinational outputs:
    - vld = !pause.
    - a = sh_a[0] & vld; b = sh_b[0] & vld.
    - last = vld & (cnt==0).
  - SHIFT, on posedge with pause=0 and cnt!=0: shift sh_a and sh_b right by 1, cnt-=1.
  - SHIFT, on posedge with pause=0 and cnt==0 (last bit emitted):
    - If in_valid=1: load the next word and stay in SHIFT (back-to-back, no bubble).
    - Else: go to IDLE.
  - SHIFT with pause=1: no register changes.
- in_ready:
  - IDLE: 1.
  - SHIFT: 1 only when pause=0 and cnt==0.
  - Never 1 during pause.
- Latency: word accepted at posedge k; its bit 0 is presented with vld=1 in the cycle after posedge k (if pause=0).
- Throughput: one bit per non-paused cycle. Words of length L back-to-back take L cycles each.
- Masking: a and b are forced to 0 whenever vld=0, including in IDLE.
- Bits of in_a and in_b above in_len are ignored and never appear on the outputs.
- last is asserted exactly once per word, on the bit with index in_len.
- Inputs in_a, in_b and in_len are sampled only on the accepting edge; later changes have no effect.
- pause asserted in IDLE: no effect; in_ready stays 1.
- A word accepted while pause=1 is not possible, because in_ready=0 in SHIFT during pause.

Optional Feature:
- Macro: SERIAL_OPERAND_FEEDER_WORD_CNT_EN.
- With the macro defined:
  - Adds output word_cnt, 8 bits, reset 0.
  - Increments on every posedge where vld=1 and last=1; wraps 255 -> 0.
- Without the macro: port absent, no counter logic.

Test Plan:
- Single word: W=8, in_a=8'h05, in_b=8'h03, in_len=3, pause=0.
  - Expected over 4 cycles: a=1,0,1,0; b=1,1,0,0; vld=1,1,1,1; last=0,0,0,1.
  - Then vld=0 and in_ready=1.
- Back-to-back: second word in_a=8'hFF, in_b=8'h01, in_len=0, with in_valid held.
  - Expected: in_ready=1 on the last bit of word 1.
  - Next cycle: vld=1, a=1, b=1, last=1; no gap between words.
- Pause mid-word: in_a=8'hA5, in_len=7, pause=1 for cycles 3-4.
  - Expected: vld=0, a=0, b=0, last=0 in the paused cycles.
  - Stream resumes with bit 2 (a=1); the 8 valid bits match 8'hA5 LSB-first.
- Max length: in_a=8'h80, in_b=8'h80, in_len=7.
  - Expected: a=1 and b=1 only on bit 7, together with last=1.
  - Same stimulus fed to the serial adder yields sum bits 0x00 (carry out of range).
- Async reset: drop rst mid-word after 2 bits.
  - Expected: outputs go to 0 immediately, without waiting for clk.
  - After release: state IDLE, in_ready=1, no residual bits.
- Counter (macro on): send 3 words.
  - Expected: word_cnt=3.
  - After 256 words total: word_cnt=0.
